// File: rtl/multdiv_pkg.sv
// Shared types and cycle-length constants for the multicycle multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Iteration counts the multdiv control drives onto limit.
    localparam int MULT_CYCLES = 16;
    localparam int DIV_CYCLES  = 32;

endpackage

// File: rtl/multdiv_cycle_counter_core.sv
// Iteration index register: synchronous clear takes priority over enable.
module counter_core #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/multdiv_cycle_counter.sv
// Programmable-length cycle sequencer with start/busy/done handshake, stall, abort and auto-reload.
module multdiv_cycle_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             stall,
    input  logic             abort,
    input  logic             reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             rel_q, rel_d;
    logic             done_d;
    logic             cnt_clr, cnt_en;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    assign busy = (state_q == RUN);
    // lim_q-1 underflows when lim_q is 0, but that only happens in IDLE where busy gates it off.
    assign last = busy && (count == (lim_q - WIDTH'(1)));

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        rel_d   = rel_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (limit != '0) begin
                        lim_d   = limit;
                        rel_d   = reload;
                        cnt_clr = 1'b1;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (!stall) begin
                    if (last) begin
                        cnt_clr = 1'b1;
                        done_d  = 1'b1;
                        state_d = rel_q ? RUN : IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lim_q   <= '0;
            rel_q   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            rel_q   <= rel_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_multdiv_cycle_counter.sv
// Directed bench for multdiv_cycle_counter: vector table plus hand-written multi-cycle sequences.
module tb_multdiv_cycle_counter;
    import multdiv_pkg::*;

    localparam int W = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] limit = '0;
    logic         stall = 1'b0;
    logic         abort = 1'b0;
    logic         reload = 1'b0;
    logic [W-1:0] count;
    logic         busy, last, done;

    int checks = 0;
    int errors = 0;

    multdiv_cycle_counter #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .limit  (limit),
        .stall  (stall),
        .abort  (abort),
        .reload (reload),
        .count  (count),
        .busy   (busy),
        .last   (last),
        .done   (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       st;
        int         lim;
        logic       stl;
        logic       abt;
        logic       rel;
        int         e_count;
        logic       e_busy;
        logic       e_last;
        logic       e_done;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input int c, input int b, input int l, input int d);
        chk({name, ".count"}, int'(count), c);
        chk({name, ".busy"}, int'(busy), b);
        chk({name, ".last"}, int'(last), l);
        chk({name, ".done"}, int'(done), d);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        start  = 1'b0;
        stall  = 1'b0;
        abort  = 1'b0;
        reload = 1'b0;
        limit  = '0;
    endtask

    task automatic do_start(input int lim, input logic rel);
        start  = 1'b1;
        limit  = W'(lim);
        reload = rel;
        step();
        quiet();
    endtask

    function automatic vec_t mk(input logic st, input int lim, input logic stl, input logic abt,
                                input logic rel, input int c, input logic b, input logic l,
                                input logic d);
        vec_t v;
        v.st = st; v.lim = lim; v.stl = stl; v.abt = abt; v.rel = rel;
        v.e_count = c; v.e_busy = b; v.e_last = l; v.e_done = d;
        return v;
    endfunction

    initial begin
        //          st lim stl abt rel   cnt busy last done   (outputs after the edge)
        vecs[0]  = mk(1, 4, 0, 0, 0,     0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0,     1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0,     1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0,     2, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0,     3, 1, 1, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0,     3, 1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 1);
        vecs[7]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 0);
        vecs[9]  = mk(1, 2, 0, 1, 0,     0, 1, 0, 0);
        vecs[10] = mk(1, 7, 0, 0, 0,     1, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0,     0, 0, 0, 1);
        vecs[12] = mk(1, 1, 0, 0, 0,     0, 1, 1, 0);
        vecs[13] = mk(0, 0, 0, 1, 0,     0, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 0, 1,     0, 1, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0,     0, 1, 1, 1);
        vecs[16] = mk(0, 0, 0, 0, 0,     0, 1, 1, 1);
        vecs[17] = mk(0, 0, 0, 1, 0,     0, 0, 0, 0);

        // Reset state
        #12;
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_all("post_reset", 0, 0, 0, 0);

        // One-shot multiply length
        do_start(MULT_CYCLES, 1'b0);
        for (int c = 0; c < MULT_CYCLES; c++) begin
            chk_all($sformatf("mult_c%0d", c), c, 1, (c == MULT_CYCLES - 1) ? 1 : 0, 0);
            step();
        end
        chk_all("mult_done", 0, 0, 0, 1);
        step();
        chk("mult_done_clears", int'(done), 0);

        // Divide length with a 3-cycle stall at count 10
        do_start(DIV_CYCLES, 1'b0);
        for (int c = 1; c <= DIV_CYCLES + 3; c++) begin
            int ec;
            stall = (c - 1 >= 10 && c - 1 <= 12);
            step();
            stall = 1'b0;
            ec = (c <= 10) ? c : (c <= 13) ? 10 : c - 3;
            if (c < DIV_CYCLES + 3)
                chk_all($sformatf("div_c%0d", c), ec, 1, (ec == DIV_CYCLES - 1) ? 1 : 0, 0);
            else
                chk_all("div_done_c35", 0, 0, 0, 1);
        end
        step();

        // Abort in the last cycle
        do_start(5, 1'b0);
        repeat (4) step();
        chk("abort_last_seen", int'(last), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("abort_next", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort_no_done%0d", i), int'(done), 0);
        end

        // Auto-reload, length 4, for 12 cycles
        do_start(4, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            step();
            chk_all($sformatf("reload_c%0d", c), c % 4, 1, (c % 4 == 3) ? 1 : 0,
                    (c % 4 == 0) ? 1 : 0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("reload_abort", 0, 0, 0, 0);
        step();
        chk("reload_abort_idle", int'(busy), 0);

        // Back-to-back, plus start ignored while busy
        do_start(3, 1'b0);
        start = 1'b1;
        limit = W'(9);
        step();
        quiet();
        chk("b2b_ignored_count", int'(count), 1);
        step();
        chk("b2b_first_last", int'(last), 1);
        step();
        chk_all("b2b_first_done", 0, 0, 0, 1);
        do_start(3, 1'b0);
        chk_all("b2b_second_c0", 0, 1, 0, 0);
        step();
        step();
        chk("b2b_second_last", int'(last), 1);
        step();
        chk_all("b2b_second_done", 0, 0, 0, 1);
        step();

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            start  = vecs[i].st;
            limit  = W'(vecs[i].lim);
            stall  = vecs[i].stl;
            abort  = vecs[i].abt;
            reload = vecs[i].rel;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_count, int'(vecs[i].e_busy),
                    int'(vecs[i].e_last), int'(vecs[i].e_done));
        end
        quiet();
        step();

        // Asynchronous reset mid-run
        do_start(10, 1'b0);
        repeat (3) step();
        chk("async_pre_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("async_no_done%0d", i), int'(done | busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_cycle_counter.md
# multdiv_cycle_counter

Parametrised cycle sequencer for the processor's multicycle multiply/divide unit. Replaces the fixed 16/32-cycle ripple toggle counter with a programmable-length counter that has a start/busy/done handshake, stall, abort and auto-reload. Sits between the decode-side `multdiv` control and the iterative multiplier/divider datapath, telling the datapath which iteration it is on and when the operation is done.

## Interface
- `WIDTH`, default 6: counter and limit width; maximum programmable length is 2^WIDTH-1 cycles.
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset (asserted when 0).
- `start`, in, 1: request a new operation; accepted only when `busy`=0.
- `limit`, in, WIDTH: operation length in cycles; sampled on an accepted `start`.
- `stall`, in, 1: when 1 in RUN, `count` holds and no progress is made.
- `abort`, in, 1: cancel the operation in progress; no `done` is produced.
- `reload`, in, 1: sampled with `start`; 1 selects auto-restart mode, 0 selects one-shot.
- `count`, out, WIDTH: current iteration index, 0..limit-1.
- `busy`, out, 1: operation in progress (state RUN).
- `last`, out, 1: `busy` and `count` = latched limit-1.
- `done`, out, 1: single-cycle pulse after the final iteration completes.

## Operation
- States: IDLE and RUN. Registers: `count`, latched limit `lim_q`, latched mode `rel_q`, `done`.
- IDLE, `start`=1, `limit`≠0: `lim_q`←`limit`, `rel_q`←`reload`, `count`←0, go to RUN.
- IDLE, `start`=1, `limit`=0: stay in IDLE and pulse `done` on the next cycle. `busy` is never asserted.
- RUN, `stall`=0, `last`=0: `count`←`count`+1.
- RUN, `stall`=0, `last`=1: `count`←0 and `done` pulses next cycle. If `rel_q`=1, stay in RUN with the same `lim_q`. Otherwise go to IDLE.
- RUN, `stall`=1: all state holds and `last` may remain high.
- Priority, highest first: `reset`, then `abort`, then `stall`, then counting.
- `abort` in RUN: next state IDLE, `count`←0, no `done`, even if `last`=1 in the same cycle.
- `abort` in IDLE: no effect. `start` in that same cycle is still accepted.
- `start` while `busy`=1: ignored. `limit` and `reload` changes during RUN: ignored.
- `done` is registered. `done` is 0 in every cycle except the one immediately following a completing edge.
- Arithmetic is unsigned WIDTH-bit. `count` never exceeds `lim_q`-1, so no wrap past 2^WIDTH-1 occurs.

## Timing
- Reset values: state IDLE, `count`=0, `lim_q`=0, `rel_q`=0, `busy`=0, `last`=0, `done`=0. All take effect immediately on `reset` falling, independent of `clock`.
- Reset asserted mid-operation: the operation is lost and no `done` is produced.
- Latency: with `start` accepted at edge 0 and no stalls:
  - `busy`=1 during cycles 0..L-1.
  - `last`=1 in cycle L-1.
  - `done`=1 and `busy`=0 in cycle L (one-shot mode).
- Each stalled cycle adds exactly one cycle to that latency.
- Back-to-back operations: `start` asserted in the cycle `done`=1 is accepted, so there are zero idle cycles between operations.
- Reload mode: `done` pulses every L non-stalled cycles while `busy` stays continuously high. Use `abort` to end the sequence.
- `busy`, `count` and `done` are direct register outputs. `last` is a combinational compare of registers only and has no input-to-output path.

## Structure
- Shared package `multdiv_pkg`:
  - State typedef with IDLE and RUN.
  - Constants `MULT_CYCLES`=16 and `DIV_CYCLES`=32, which callers drive onto `limit`.
- One sub-module: `counter_core`, a WIDTH-bit register with asynchronous active-low reset, synchronous clear and enable, producing `count`. All FSM logic stays in `multdiv_cycle_counter`.

## Test plan
- Reset then `start` with `limit`=16, `reload`=0, no stalls:
  - `count` steps 0..15.
  - `last` is high only in cycle 15.
  - `done` is high in cycle 16 with `busy`=0.
- `limit`=32 with `stall` high for 3 cycles at `count`=10: `count` holds at 10 for 3 cycles and `done` arrives in cycle 35.
- `abort` in the `last` cycle of a `limit`=5 run: next cycle `busy`=0 and `count`=0, and `done` never pulses.
- `reload`=1, `limit`=4 for 12 cycles:
  - `done` pulses in cycles 4, 8 and 12.
  - `busy` stays 1 throughout.
  - `abort` then returns the block to IDLE.
- Back-to-back: `start` (`limit`=3) asserted in a `done` cycle is accepted, giving a second `done` 3 cycles later. `start` asserted while `busy`=1 is ignored.
- `limit`=0 `start` gives `done` the next cycle with `busy` staying 0. `reset` pulsed low mid-run clears all outputs asynchronously, before the next `clock` edge.
